// File: rtl/cic_interp_var_if.sv
// cic_interp_var_if: sample handshake bundle for the TX CIC interpolator
// Signals:
//   in_req     interpolator -> FIFO   one-clock pulse requesting the next input sample
//   in_valid   FIFO -> interpolator   one-clock pulse, in_data valid
//   in_data    FIFO -> interpolator   signed input sample
//   out_ce     DAC path -> interp.    output-rate tick, one clock wide
//   out_strobe interp. -> DAC path    one-clock pulse, out_data updated
//   out_data   interp. -> DAC path    signed output sample
// slave is the interpolator view, master is the surrounding datapath view.
interface cic_interp_var_if #(
    parameter int IN_WIDTH  = 18,
    parameter int OUT_WIDTH = 18
);
    logic                        in_req;
    logic                        in_valid;
    logic signed [IN_WIDTH-1:0]  in_data;
    logic                        out_ce;
    logic                        out_strobe;
    logic signed [OUT_WIDTH-1:0] out_data;
    modport master (input in_req, out_strobe, out_data, output in_valid, in_data, out_ce);
    modport slave  (output in_req, out_strobe, out_data, input in_valid, in_data, out_ce);
endinterface

// File: rtl/cic_interp_var.sv
// cic_interp_var: variable-ratio STAGES-stage CIC interpolator for the TX path
// Ports:
//   clock          system clock, rising edge
//   reset_n        asynchronous active-low reset
//   enable         run enable, low returns to IDLE
//   interpolation  requested ratio R (4,5,8,10,16,20,32,40 supported)
//   ratio_err      high while the latched ratio is unsupported
//   underrun       sticky, set when a consumption finds no sample
//   bus            cic_interp_var_if.slave (in_req/in_valid/in_data, out_ce/out_strobe/out_data)
// Optional: define CIC_INTERP_ROUND_EN for round-half-up with saturation instead of truncation.
module cic_interp_var #(
    parameter int STAGES    = 5,
    parameter int IN_WIDTH  = 18,
    parameter int ACC_WIDTH = 45,
    parameter int OUT_WIDTH = 18
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [5:0]            interpolation,
    output logic                  ratio_err,
    output logic                  underrun,
    cic_interp_var_if.slave       bus
);
    localparam int SW = $clog2(ACC_WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t state, state_nxt;
    logic [5:0] ratio_q, ph;
    logic [SW-1:0] shift;
    logic last, wrap, cons, ratio_ok, hold_full;
    logic signed [IN_WIDTH-1:0] hold, x;
    logic signed [ACC_WIDTH-1:0] dly [STAGES];
    logic signed [ACC_WIDTH-1:0] diff [STAGES+1];
    logic signed [ACC_WIDTH-1:0] integ [STAGES];
    logic signed [OUT_WIDTH-1:0] res;

    // ratio 0 and 1 collapse to a one-tick frame so requests still go out every out_ce
    assign last = ratio_q <= 6'd1 || ph == ratio_q - 6'd1;
    assign wrap = state == RUN && bus.out_ce && last;
    assign cons = state == RUN && bus.out_ce && ph == '0;
    // a sample arriving on the consumption clock bypasses the hold register
    assign x = bus.in_valid ? bus.in_data : hold_full ? hold : '0;
    assign diff[0] = {{(ACC_WIDTH-IN_WIDTH){x[IN_WIDTH-1]}}, x};
    for (genvar g = 0; g < STAGES; g++) begin : g_comb
        assign diff[g+1] = diff[g] - dly[g];
    end

    always_comb begin
        shift = SW'(8);
        ratio_ok = 1'b1;
        case (ratio_q)
            6'd4:    shift = SW'(8);
            6'd5:    shift = SW'(10);
            6'd8:    shift = SW'(12);
            6'd10:   shift = SW'(14);
            6'd16:   shift = SW'(16);
            6'd20:   shift = SW'(18);
            6'd32:   shift = SW'(20);
            6'd40:   shift = SW'(22);
            default: ratio_ok = 1'b0;
        endcase
    end

`ifdef CIC_INTERP_ROUND_EN
    localparam logic signed [ACC_WIDTH-1:0] MAXV = {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MINV = {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    logic signed [ACC_WIDTH-1:0] sh, rnd;
    assign sh  = integ[STAGES-1] >>> shift;
    assign rnd = sh + {{(ACC_WIDTH-1){1'b0}}, integ[STAGES-1][shift - 1'b1]};
    assign res = rnd > MAXV ? OUT_WIDTH'(MAXV) : rnd < MINV ? OUT_WIDTH'(MINV) : OUT_WIDTH'(rnd);
`else
    assign res = OUT_WIDTH'(integ[STAGES-1] >>> shift);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nxt;
    end

    // a ratio change is only honoured at a frame boundary so no frame is cut short
    always_comb begin
        state_nxt = state == IDLE  ? (enable ? RUN : IDLE)
                  : state == FLUSH ? RUN
                  : !enable        ? IDLE
                  : (wrap && interpolation != ratio_q) ? FLUSH : RUN;
    end

    always_comb begin
        bus.in_req = wrap;
        ratio_err  = state != IDLE && !ratio_ok;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ratio_q        <= '0;
            ph             <= '0;
            hold           <= '0;
            hold_full      <= 1'b0;
            underrun       <= 1'b0;
            bus.out_strobe <= 1'b0;
            bus.out_data   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                dly[i]   <= '0;
                integ[i] <= '0;
            end
        end else if (state != RUN) begin
            // IDLE and FLUSH both park the filter in a clean, cleared state
            ph             <= '0;
            bus.out_strobe <= 1'b0;
            hold           <= bus.in_valid ? bus.in_data : hold;
            hold_full      <= state == FLUSH && bus.in_valid;
            ratio_q        <= (state == FLUSH || enable) ? interpolation : ratio_q;
            underrun       <= (state == IDLE && enable) ? 1'b0 : underrun;
            for (int i = 0; i < STAGES; i++) begin
                dly[i]   <= '0;
                integ[i] <= '0;
            end
        end else begin
            hold      <= bus.in_valid ? bus.in_data : hold;
            hold_full <= !cons && (bus.in_valid || hold_full);
            underrun  <= underrun || (cons && !bus.in_valid && !hold_full);
            if (cons)
                for (int i = 0; i < STAGES; i++) dly[i] <= diff[i];
            if (bus.out_ce) begin
                ph       <= last ? '0 : ph + 6'd1;
                integ[0] <= integ[0] + (ph == '0 ? diff[STAGES] : '0);
                for (int i = 1; i < STAGES; i++) integ[i] <= integ[i] + integ[i-1];
            end
            bus.out_strobe <= bus.out_ce && state_nxt == RUN;
            bus.out_data   <= state_nxt == FLUSH ? '0
                            : (bus.out_ce && state_nxt == RUN) ? (ratio_ok ? res : '0)
                            : bus.out_data;
        end
    end
endmodule

// File: tb/tb_cic_interp_var.sv
// tb_cic_interp_var: directed bench for the CIC interpolator (DC gain, underrun, ratio change, bad ratio, reset)
module tb_cic_interp_var;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic [5:0] interpolation = '0;
    logic ratio_err, underrun;
    cic_interp_var_if bus();

    cic_interp_var dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .interpolation(interpolation),
        .ratio_err(ratio_err), .underrun(underrun), .bus(bus)
    );

    always #5 clock = ~clock;

    int tests = 0, errors = 0;
    int ce_div = 2, div_cnt = 0, ce_cnt = 0, prev_req_ce = 0, req_cnt = 0;
    int strobe_cnt = 0, nz_cnt = 0, mon_bad = 0, lag_bad = 0, flush_cnt = 0;
    int skip_resp = 0, first_ur_ce = -1, exp_dc = 0, dc_val = 0;
    int gaps[$];
    logic ce_en = 1'b0, prime = 1'b0, resp_pending = 1'b0, chk_en = 1'b0;
    logic prev_ce = 1'b0, prev_ur = 1'b0;
    logic signed [17:0] out_prev = '0;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // drives out_ce/in_valid on the falling edge, samples everything 2 time units later
    always @(negedge clock) begin
        bus.in_valid = resp_pending || prime;
        bus.in_data  = 18'(dc_val);
        resp_pending = 1'b0;
        prime = 1'b0;
        if (ce_en) begin
            div_cnt++;
            bus.out_ce = div_cnt >= ce_div;
            if (bus.out_ce) div_cnt = 0;
        end else begin
            div_cnt = 0;
            bus.out_ce = 1'b0;
        end
        #2;
        if (bus.out_ce) ce_cnt++;
        if (bus.in_req) begin
            req_cnt++;
            gaps.push_back(ce_cnt - prev_req_ce);
            prev_req_ce = ce_cnt;
            if (skip_resp > 0) skip_resp--;
            else resp_pending = 1'b1;
        end
        if (bus.out_strobe) begin
            strobe_cnt++;
            if (bus.out_data != 0) nz_cnt++;
            if (chk_en && bus.out_data != exp_dc) mon_bad++;
            if (!prev_ce) lag_bad++;
        end else if (bus.out_data == 0 && out_prev != 0) flush_cnt++;
        if (underrun && !prev_ur) first_ur_ce = ce_cnt - prev_req_ce;
        prev_ur  = underrun;
        prev_ce  = bus.out_ce;
        out_prev = bus.out_data;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
        #3;
    endtask

    task automatic start(input int r, input int v);
        ce_en = 1'b0;
        enable = 1'b0;
        tick(3);
        interpolation = 6'(r);
        dc_val = v;
        enable = 1'b1;
        prime = 1'b1;
        ce_en = 1'b1;
        prev_req_ce = ce_cnt;
        gaps.delete();
    endtask

    task automatic settle_check(input string tag, input int expv, input int settle, input int window);
        tick(settle);
        mon_bad = 0;
        strobe_cnt = 0;
        exp_dc = expv;
        chk_en = 1'b1;
        tick(window);
        chk_en = 1'b0;
        check({tag, "_dc"}, mon_bad, 0);
        check({tag, "_strobes"}, strobe_cnt, window / ce_div);
        check({tag, "_last_out"}, bus.out_data, expv);
    endtask

    task automatic wait_req(input string tag, input int bound);
        int r0 = req_cnt;
        int n = 0;
        while (req_cnt == r0 && n < bound) begin
            tick(1);
            n++;
        end
        if (req_cnt == r0) check({tag, "_timeout"}, 0, 1);
    endtask

    function automatic int gap_bad(input int expg, input int from);
        int b = 0;
        for (int i = from; i < gaps.size(); i++) if (gaps[i] != expg) b++;
        return b;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ce   = 1'b0;
        tick(3);
        check("rst_out_data", bus.out_data, 0);
        check("rst_strobe", bus.out_strobe, 0);
        check("rst_req", bus.in_req, 0);
        check("rst_ratio_err", ratio_err, 0);
        check("rst_underrun", underrun, 0);
        reset_n = 1'b1;
        tick(2);

        start(4, 1000);
        settle_check("r4", 1000, 150, 100);
        check("r4_gap", gap_bad(4, 0), 0);
        check("r4_reqs", int'(gaps.size() > 20), 1);
        check("r4_underrun", underrun, 0);
        check("r4_ratio_err", ratio_err, 0);

        start(10, 1000);
        settle_check("r10_pos", 610, 300, 100);
        start(10, -1000);
`ifdef CIC_INTERP_ROUND_EN
        settle_check("r10_neg", -610, 300, 100);
`else
        settle_check("r10_neg", -611, 300, 100);
`endif

        start(5, 1000);
        tick(200);
        check("ur_clean", underrun, 0);
        first_ur_ce = -1;
        skip_resp = 1;
        tick(60);
        check("ur_flag", underrun, 1);
        check("ur_at_ph0", first_ur_ce, 1);
        settle_check("ur_recover", 610, 200, 100);
        check("ur_sticky", underrun, 1);
        check("ur_gap", gap_bad(5, 0), 0);

        start(10, 1000);
        tick(300);
        wait_req("rc", 100);
        tick(5);
        flush_cnt = 0;
        gaps.delete();
        interpolation = 6'd20;
        settle_check("rc", 610, 400, 100);
        check("rc_flush", flush_cnt, 1);
        check("rc_gap_old", gaps.size() > 0 ? gaps[0] : -1, 10);
        check("rc_gap_new", gaps.size() > 1 ? gaps[1] : -1, 20);
        check("rc_gap_rest", gap_bad(20, 1), 0);
        check("rc_ratio_err", ratio_err, 0);

        start(7, 1000);
        tick(100);
        check("bad_ratio_err", ratio_err, 1);
        strobe_cnt = 0;
        nz_cnt = 0;
        tick(100);
        check("bad_out_zero", nz_cnt, 0);
        check("bad_strobes", strobe_cnt, 50);
        check("bad_gap", gap_bad(7, 0), 0);
        interpolation = 6'd8;
        tick(40);
        check("bad_fixed", ratio_err, 0);
        settle_check("r8", 1000, 300, 100);

        wait_req("rst", 100);
        while (ce_cnt - prev_req_ce < 3) tick(1);
        tick(1);
        reset_n = 1'b0;
        #1;
        check("arst_out_data", bus.out_data, 0);
        check("arst_strobe", bus.out_strobe, 0);
        check("arst_req", bus.in_req, 0);
        check("arst_underrun", underrun, 0);
        ce_en = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        prev_req_ce = ce_cnt;
        gaps.delete();
        ce_en = 1'b1;
        wait_req("rst_first", 100);
        check("rst_first_req_gap", gaps.size() > 0 ? gaps[0] : -1, 8);
        check("strobe_lag", lag_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/cic_interp_var.md
Name: cic_interp_var

Overview:
- Variable-ratio 5-stage CIC interpolator for the transmit path; the transmit-side counterpart of the receive CIC decimator.
- Takes baseband samples at low rate and produces samples at the rate of an external output clock-enable, with interpolation ratio R.
- Pulls input samples with a request/valid handshake.
- Sits between the TX baseband FIFO and the TX CORDIC/DAC path.

Parameters:
- STAGES, 5, number of comb stages and number of integrator stages.
- IN_WIDTH, 18, signed input sample width.
- ACC_WIDTH, 45, comb/integrator accumulator width; must be at least IN_WIDTH + STAGES + 22.
- OUT_WIDTH, 18, signed output sample width.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  run enable; low forces IDLE.
- interpolation  in  6  ratio R; supported values are 4, 5, 8, 10, 16, 20, 32, 40.
- out_ce  in  1  output-rate tick, one clock wide.
- in_req  out  1  one-clock pulse requesting the next input sample.
- in_valid  in  1  one-clock pulse; in_data is valid on this cycle.
- in_data  in  IN_WIDTH  signed input sample.
- out_strobe  out  1  one-clock pulse; out_data is updated.
- out_data  out  OUT_WIDTH  signed output sample.
- ratio_err  out  1  level; high while the latched R is unsupported.
- underrun  out  1  sticky flag; cleared only by reset or by leaving IDLE.

Behaviour:
- Reset: all outputs, accumulators, the hold register, the phase counter and ratio_q go to 0. State goes to IDLE.
- Phase counter: ph counts out_ce ticks 0..ratio_q-1 and wraps to 0.
- Request: in_req pulses on the clock of an out_ce where ph == ratio_q-1.
- Hold register: in_valid loads in_data into a hold register and sets hold_full.
- Input consumption: on out_ce with ph == 0, the comb chain consumes the hold register and clears hold_full.
  - If hold_full == 0 at that point, the combs consume 0 and underrun is set.
  - If in_valid and consumption fall on the same cycle, the new in_data is consumed directly and hold_full stays 0.
- Comb chain: the STAGES registered comb stages update only on consumption. Comb inputs are sign-extended to ACC_WIDTH.
- Zero-stuffing: integrator stage 0 input is the comb output on out_ce with ph == 0, and 0 on every other out_ce.
- Integrators: all update on every out_ce. Arithmetic is two's-complement and wraps modulo 2^ACC_WIDTH; the CIC property guarantees a correct result.
- Gain and shift: gain is R^(STAGES-1). Output slice is [SHIFT+OUT_WIDTH-1 : SHIFT] of the last integrator, with SHIFT per R:
  - R=4 → 8, R=5 → 10, R=8 → 12, R=10 → 14.
  - R=16 → 16, R=20 → 18, R=32 → 20, R=40 → 22.
- Output timing: one clock after each out_ce, out_data is updated and out_strobe pulses. out_strobe therefore lags out_ce by exactly one clock.
- States:
  - IDLE: accumulators held at 0; no in_req and no out_strobe.
    - enable=1 → latch ratio_q = interpolation, clear underrun, set ph=0, go to RUN.
  - RUN: normal operation.
    - On every ph wrap (out_ce with ph == ratio_q-1), if interpolation != ratio_q → go to FLUSH.
    - enable=0 → IDLE, effective on the next clock.
  - FLUSH: exactly one clock.
    - Clear all comb/integrator registers and hold_full, latch the new ratio_q, set ph=0, go to RUN.
    - out_data is forced to 0; no out_strobe is issued in this clock.
- Unsupported ratio_q (including 0 and 1):
  - ratio_err=1.
  - The block still runs and requests samples at ratio_q. If ratio_q is 0 or 1, it requests on every out_ce.
  - out_data is forced to 0; out_strobe still pulses.
- Reset asserted mid-frame: immediate return to reset values, with no partial outputs.

Optional Feature:
- Macro: CIC_INTERP_ROUND_EN.
- Defined: output is rounded half-up by adding bit [SHIFT-1] to the slice. It saturates to +2^(OUT_WIDTH-1)-1 when the rounding increment would overflow and to the negative full-scale value on negative overflow of the slice. No wrap is allowed.
- Undefined: plain truncation of the slice; no saturation logic is generated.

Test Plan:
- DC, unity gain: R=4, in_data=1000 on every request, out_ce every 2 clocks. After 2*STAGES frames, every out_data = 1000; in_req exactly once per 4 out_ce.
- DC with shift: R=10, in_data=1000. Steady-state out_data = 610 (1000*10^4/2^14 = 610.35), with or without CIC_INTERP_ROUND_EN. in_data=-1000 gives -611 truncated and -610 rounded.
- Underrun: R=5, in_valid withheld for one request. underrun rises on the ph==0 out_ce and stays high; the output is the zero-input response, with no hang and no extra in_req.
- Ratio change: switch interpolation 10→20 mid-frame. The change takes effect only at the ph wrap; there is one FLUSH clock with out_data=0; in_req spacing then becomes 20 out_ce; DC 1000 settles to 1000*20^4/2^18 = 610.
- Unsupported ratio: interpolation=7. ratio_err=1, out_data=0, out_strobe continues. Set interpolation=8 → FLUSH at the next wrap, then ratio_err=0.
- Reset mid-frame: assert reset_n low at ph=3, R=8. All outputs are 0 asynchronously. After release with enable=1, the first in_req occurs after exactly 8 out_ce.
